// File: rtl/muldiv_if.sv
// Request/response bundle between the control unit and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      md_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] md_data;

  modport master (
    output start, md_op, operand_a, operand_b,
    input  busy, done, md_data
  );

  modport slave (
    input  start, md_op, operand_a, operand_b,
    output busy, done, md_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-subtract steps on operand magnitudes,
// sign fix-up in a final cycle; fixed 33-cycle latency, start ignored while busy.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave md
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'd31;

  state_t          state_q;
  state_t          state_d;
  logic [5:0]      cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN:0]   acc_hi_q;
  logic [XLEN-1:0] acc_lo_q;
  logic [XLEN-1:0] opnd_q;
  logic            done_q;
  logic [XLEN-1:0] md_data_q;

  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            b_zero;
  logic            neg_start;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN:0]   step_hi;
  logic [XLEN-1:0] step_lo;

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   result;

  // Operand conditioning at the start edge; the sign flag is already specific to the selected result.
  always_comb begin
    a_signed  = (md.md_op == 3'd1) || (md.md_op == 3'd2) || (md.md_op == 3'd4) || (md.md_op == 3'd6);
    b_signed  = (md.md_op == 3'd1) || (md.md_op == 3'd4) || (md.md_op == 3'd6);
    sign_a    = a_signed & md.operand_a[XLEN-1];
    sign_b    = b_signed & md.operand_b[XLEN-1];
    mag_a     = sign_a ? ('0 - md.operand_a) : md.operand_a;
    mag_b     = sign_b ? ('0 - md.operand_b) : md.operand_b;
    b_zero    = (md.operand_b == '0);
    neg_start = 1'b0;
    if (!md.md_op[2]) begin
      neg_start = sign_a ^ sign_b;
    end else if (md.md_op[1]) begin
      neg_start = sign_a;
    end else begin
      // Divide by zero must return an all-ones quotient regardless of the dividend sign.
      neg_start = (sign_a ^ sign_b) & ~b_zero;
    end
  end

  // One iteration step. Unsigned restoring division by zero naturally yields all-ones quotient and
  // remainder = dividend; the signed overflow case also falls out of magnitude arithmetic unchanged.
  always_comb begin
    mul_sum   = acc_hi_q + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
    div_shift = {acc_hi_q[XLEN-1:0], acc_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    step_hi   = {1'b0, mul_sum[XLEN:1]};
    step_lo   = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff;
        step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift;
        step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod   = {acc_hi_q[XLEN-1:0], acc_lo_q};
    prod_s = neg_q ? ('0 - prod) : prod;
    quo_s  = neg_q ? ('0 - acc_lo_q) : acc_lo_q;
    rem_s  = neg_q ? ('0 - acc_hi_q[XLEN-1:0]) : acc_hi_q[XLEN-1:0];
    case (op_q)
      3'd0:                result = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    result = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          result = quo_s;
      default:             result = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md.start) state_d = CALC;
      CALC:    if (cnt_q == LAST_ITER) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      done_q    <= 1'b0;
      md_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (md.start) begin
            cnt_q    <= '0;
            op_q     <= md.md_op;
            neg_q    <= neg_start;
            acc_hi_q <= '0;
            // Multiply shifts the multiplier out of acc_lo; divide shifts the dividend out of it.
            acc_lo_q <= md.md_op[2] ? mag_a : mag_b;
            opnd_q   <= md.md_op[2] ? mag_b : mag_a;
          end
        end
        CALC: begin
          cnt_q    <= cnt_q + 6'd1;
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
        end
        FIN: begin
          md_data_q <= result;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign md.busy    = (state_q != IDLE);
  assign md.done    = done_q;
  assign md.md_data = md_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: result table, fixed latency, start masking, back-to-back, reset abort.
module tb_muldiv_unit;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   passes;
  int   total;

  muldiv_if md ();

  muldiv_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .md   (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Starts one op at the next rising edge (E0) and returns the number of falling edges after E0 until
  // done is seen; done after E0+33 appears at the 34th falling edge. Operands are scrambled after E0.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_err);
    @(negedge clk);
    md.start = 1'b1; md.md_op = op; md.operand_a = a; md.operand_b = b;
    @(negedge clk);
    md.start = 1'b0; md.md_op = ~op; md.operand_a = 32'hDEADBEEF; md.operand_b = 32'h12345678;
    lat = 1;
    busy_err = 0;
    while (!md.done && lat < 100) begin
      if (!md.busy) busy_err++;
      @(negedge clk);
      lat++;
    end
    if (md.busy) busy_err++;
    res = md.md_data;
  endtask

  vec_t vecs[14];

  initial begin
    logic [31:0] res;
    int lat;
    int berr;
    int k;
    int extra;

    passes = 0;
    total  = 0;
    vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'h0000000E};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'h00000002};
    vecs[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'h00000005};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{3'd5, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
    vecs[13] = '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};

    rst_n = 1'b0;
    md.start = 1'b0; md.md_op = 3'd0; md.operand_a = '0; md.operand_b = '0;
    #1;
    check("reset_busy", {31'd0, md.busy}, 32'd0);
    check("reset_done", {31'd0, md.done}, 32'd0);
    check("reset_data", md.md_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, berr);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, 32'd34);
      check($sformatf("vec%0d_busy", i), berr, 32'd0);
    end

    // Start during a running MUL must be ignored.
    @(negedge clk);
    md.start = 1'b1; md.md_op = 3'd0; md.operand_a = 32'd7; md.operand_b = 32'hFFFFFFFD;
    @(negedge clk);
    for (k = 1; k < 100 && !md.done; k++) begin
      if (k == 10) begin
        md.start = 1'b1; md.md_op = 3'd5; md.operand_a = 32'd9; md.operand_b = 32'd3;
      end else begin
        md.start = 1'b0;
      end
      @(negedge clk);
    end
    check("ignored_start_latency", k, 32'd34);
    check("ignored_start_result", md.md_data, 32'hFFFFFFEB);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (md.done) extra++;
    end
    check("ignored_start_no_done", extra, 32'd0);

    // Back-to-back: start held in the done cycle.
    md.start = 1'b1; md.md_op = 3'd0; md.operand_a = 32'd7; md.operand_b = 32'hFFFFFFFD;
    @(negedge clk);
    md.start = 1'b0;
    for (k = 1; k < 100 && !md.done; k++) @(negedge clk);
    check("b2b_first_latency", k, 32'd34);
    check("b2b_first_result", md.md_data, 32'hFFFFFFEB);
    md.start = 1'b1; md.md_op = 3'd5; md.operand_a = 32'd100; md.operand_b = 32'd7;
    @(negedge clk);
    md.start = 1'b0;
    for (k = 35; k < 150 && !md.done; k++) begin
      if (k == 50) check("b2b_data_held", md.md_data, 32'hFFFFFFEB);
      @(negedge clk);
    end
    check("b2b_second_latency", k, 32'd68);
    check("b2b_second_result", md.md_data, 32'h0000000E);

    // Reset in the middle of a DIV.
    @(negedge clk);
    md.start = 1'b1; md.md_op = 3'd4; md.operand_a = 32'd100; md.operand_b = 32'd7;
    @(negedge clk);
    md.start = 1'b0;
    for (k = 1; k < 12; k++) @(negedge clk);
    check("midop_busy_before", {31'd0, md.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midop_reset_busy", {31'd0, md.busy}, 32'd0);
    check("midop_reset_data", md.md_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (md.done || md.busy) extra++;
    end
    check("midop_no_done", extra, 32'd0);

    // Start presented in the same cycle reset is released is taken at the first edge.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    md.start = 1'b1; md.md_op = 3'd7; md.operand_a = 32'd100; md.operand_b = 32'd7;
    @(negedge clk);
    md.start = 1'b0;
    for (k = 1; k < 100 && !md.done; k++) @(negedge clk);
    check("post_reset_latency", k, 32'd34);
    check("post_reset_result", md.md_data, 32'h00000002);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the single-cycle core: sits beside `alu` and takes the same operand pair, with the operation selected from the decoded funct3. It accepts a one-cycle `start` request, performs 32 shift-add (multiply) or restoring-subtract (divide) iterations, and returns the result with a one-cycle `done` pulse. While `busy` is high, the control unit stalls the PC.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request strobe; sampled only in IDLE.
- `md_op`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `operand_a`  in  32  rs1 value (multiplicand / dividend).
- `operand_b`  in  32  rs2 value (multiplier / divisor).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `md_data` is valid in this cycle.
- `md_data`  out  32  result; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIN.
- IDLE, `start`=1 on an edge:
  - latch `md_op`.
  - latch the magnitudes of the operands: signed operands use the absolute value; `abs(0x80000000)` = 0x80000000 taken as unsigned.
  - latch the result sign flag.
  - clear the 6-bit iteration counter.
  - go to CALC.
- CALC: one iteration per edge; after 32 iterations go to FIN.
  - Multiply: 64-bit shift-add on the magnitudes.
  - Divide: restoring division, 32-bit quotient and 33-bit partial remainder.
- FIN, one edge:
  - apply sign correction (two's-complement negate where required).
  - select the result, register it into `md_data`.
  - pulse `done`, return to IDLE.
- Result select:
  - MUL: low 32 bits of the product.
  - MULH, MULHSU, MULHU: high 32 bits of the product.
  - DIV, DIVU: quotient. REM, REMU: remainder.
- Signedness:
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
  - DIV and REM signed; DIVU and REMU unsigned.
  - Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of the dividend.
- Divide by zero (b=0):
  - quotient = 0xFFFFFFFF for both DIV and DIVU.
  - remainder = a.
- Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF):
  - quotient = 0x80000000, remainder = 0.
- Special cases are resolved in FIN and take the full latency; there is no early exit.
- Operand inputs are not observed after the start edge; they may change freely.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE, `busy`=0, `done`=0, `md_data`=0, counter=0, all datapath registers cleared.
- Reset asserted mid-operation: the operation is aborted immediately, no `done` is produced, and the unit accepts `start` on the first edge after release.
- Start sampled at edge E0:
  - `busy`=1 from after E0 through edge E0+33.
  - Iterations run on edges E0+1 to E0+32.
  - FIN executes at E0+33.
- After E0+33: `done`=1 and `busy`=0 for exactly one cycle. `md_data` is valid from then on and is held.
- Fixed latency: 33 cycles from the start edge to the `done` edge, for every op.
- `start` while `busy`=1 is ignored; no queueing, no effect on the running operation.
- `start`=1 in the `done` cycle is a legal back-to-back request: it is sampled at E0+34.
- `md_data` changes only at a FIN edge or on reset.

## Test plan
- Reset, then MUL a=0x00000007, b=0xFFFFFFFD with `start` at edge 0:
  - `busy` high for cycles 1–33.
  - `done` for a single cycle after edge 33.
  - `md_data`=0xFFFFFFEB.
- High multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV −7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD.
  - REM −7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 0x0000000E.
  - REMU 100/7 -> 0x00000002.
- Corner cases:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 0x00000005.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0x00000000.
- Handshake:
  - Second `start` (DIVU 9/3) at cycle 10 of a running MUL: ignored; the MUL result is returned at cycle 33.
  - `start` held high in the `done` cycle: accepted, second `done` after edge 67.
- Reset during operation: `rst_n` low at cycle 12 of a DIV -> `busy`=0, `md_data`=0 immediately, and no `done` pulse occurs afterwards.
